// File: rtl/imm_encoder.sv
// imm_encoder
//   Packs a sign-extended 32-bit immediate plus register/opcode fields into a
//   RISC-V instruction word (I, S, B or U format). Each request is range-checked
//   for its format. Out-of-range requests produce an all-zero word flagged
//   with out_err. Results are queued in a 2-entry FIFO with valid/ready on
//   both sides. Two saturating counters track accepted good and rejected
//   requests.
//
// Ports
//   clk, rst_n        : clock; asynchronous active-low reset
//   in_valid/in_ready : request handshake (in_ready depends only on FIFO state)
//   imm               : sign-extended immediate
//   imm_src           : format select 00 I, 01 S, 10 B, 11 U
//   opcode, funct3    : instruction[6:0], instruction[14:12] (funct3 unused for U)
//   rd, rs1, rs2      : register fields; unused ones for a format are ignored
//   out_valid/out_ready : FIFO head handshake
//   out_instr, out_err  : FIFO head word and range-reject flag
//   pack_count, err_count : saturating counts of accepted good / rejected requests
module imm_encoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      imm,
    input  logic [1:0]       imm_src,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] pack_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        FMT_I = 2'b00,
        FMT_S = 2'b01,
        FMT_B = 2'b10,
        FMT_U = 2'b11
    } fmt_t;

    fmt_t        fmt;
    logic [31:0] packed_instr;
    logic        in_range;

    assign fmt = fmt_t'(imm_src);

    // Format packing and representability check
    always_comb begin
        packed_instr = '0;
        in_range     = 1'b0;
        unique case (fmt)
            FMT_I: begin
                packed_instr = {imm[11:0], rs1, funct3, rd, opcode};
                in_range     = (imm[31:11] == '0) || (imm[31:11] == '1);
            end
            FMT_S: begin
                packed_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                in_range     = (imm[31:11] == '0) || (imm[31:11] == '1);
            end
            FMT_B: begin
                packed_instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                                imm[4:1], imm[11], opcode};
                in_range     = ((imm[31:12] == '0) || (imm[31:12] == '1))
                               && (imm[0] == 1'b0);
            end
            FMT_U: begin
                packed_instr = {imm[31:12], rd, opcode};
                in_range     = (imm[11:0] == '0);
            end
            default: begin
                packed_instr = '0;
                in_range     = 1'b0;
            end
        endcase
    end

    // 2-entry FIFO, entry = {instr, err}
    logic [32:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;
    logic [32:0] entry;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign entry     = in_range ? {packed_instr, 1'b0} : {32'h0, 1'b1};

    assign out_instr = mem[rd_ptr][32:1];
    assign out_err   = mem[rd_ptr][0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Saturating counters, exactly one bumps per accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_count <= '0;
            err_count  <= '0;
        end else if (push) begin
            if (in_range) begin
                if (pack_count != '1) begin
                    pack_count <= pack_count + CNT_W'(1);
                end
            end else begin
                if (err_count != '1) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder
//   Directed-vector bench for imm_encoder. Expected instruction words are
//   hand-computed from the RISC-V field layouts. A second instance with
//   CNT_W=4 exercises counter saturation.
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] imm;
    logic [1:0]  imm_src;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] pack_count;
    logic [15:0] err_count;

    logic        in_valid4;
    logic        in_ready4;
    logic        out_valid4;
    logic        out_ready4;
    logic [31:0] out_instr4;
    logic        out_err4;
    logic [3:0]  pack_count4;
    logic [3:0]  err_count4;

    int unsigned n_checks;
    int unsigned n_fail;

    imm_encoder #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imm        (imm),
        .imm_src    (imm_src),
        .opcode     (opcode),
        .funct3     (funct3),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_err    (out_err),
        .pack_count (pack_count),
        .err_count  (err_count)
    );

    imm_encoder #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid4),
        .in_ready   (in_ready4),
        .imm        (imm),
        .imm_src    (imm_src),
        .opcode     (opcode),
        .funct3     (funct3),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .out_valid  (out_valid4),
        .out_ready  (out_ready4),
        .out_instr  (out_instr4),
        .out_err    (out_err4),
        .pack_count (pack_count4),
        .err_count  (err_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] src, input logic [31:0] im,
                           input logic [6:0] op, input logic [2:0] f3,
                           input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2);
        imm_src = src;
        imm     = im;
        opcode  = op;
        funct3  = f3;
        rd      = d;
        rs1     = s1;
        rs2     = s2;
    endtask

    // One request with out_ready=1: accept, check head, then let it drain.
    task automatic send(input string tag, input logic [1:0] src,
                        input logic [31:0] im, input logic [6:0] op,
                        input logic [2:0] f3, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] exp_instr, input logic exp_err);
        set_req(src, im, op, f3, d, s1, s2);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".valid"}, {31'h0, out_valid}, 32'h1);
        check({tag, ".instr"}, out_instr, exp_instr);
        check({tag, ".err"},   {31'h0, out_err}, {31'h0, exp_err});
        @(posedge clk); #1;
        check({tag, ".drain"}, {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_valid4  = 1'b0;
        out_ready  = 1'b1;
        out_ready4 = 1'b1;
        set_req(2'b00, 32'h0, 7'h0, 3'h0, 5'h0, 5'h0, 5'h0);

        #12;
        check("rst.out_valid",  {31'h0, out_valid}, 32'h0);
        check("rst.in_ready",   {31'h0, in_ready},  32'h1);
        check("rst.out_instr",  out_instr, 32'h0);
        check("rst.out_err",    {31'h0, out_err},   32'h0);
        check("rst.pack_count", {16'h0, pack_count}, 32'h0);
        check("rst.err_count",  {16'h0, err_count},  32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Encodings
        send("enc_i", 2'b00, 32'hFFFFF800, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0,
             32'h80010093, 1'b0);
        check("enc_i.pack_count", {16'h0, pack_count}, 32'd1);
        send("enc_s", 2'b01, 32'h00000008, 7'h23, 3'd2, 5'd0, 5'd2, 5'd5,
             32'h00512423, 1'b0);
        send("enc_b", 2'b10, 32'hFFFFFFFC, 7'h63, 3'd1, 5'd0, 5'd1, 5'd0,
             32'hFE009EE3, 1'b0);

        // Range rejects
        send("rej_i", 2'b00, 32'h00000800, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0,
             32'h0, 1'b1);
        send("rej_b", 2'b10, 32'h00000003, 7'h63, 3'd1, 5'd0, 5'd1, 5'd0,
             32'h0, 1'b1);
        send("rej_u", 2'b11, 32'h00001001, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0,
             32'h0, 1'b1);
        check("rej.err_count",  {16'h0, err_count},  32'd3);
        check("rej.pack_count", {16'h0, pack_count}, 32'd3);

        send("enc_u", 2'b11, 32'h12345000, 7'h37, 3'd7, 5'd5, 5'd9, 5'd9,
             32'h123452B7, 1'b0);
        // Unused rs2/garbage fields must not leak into I format
        send("enc_i_rs2", 2'b00, 32'hFFFFF800, 7'h13, 3'd0, 5'd1, 5'd2, 5'd31,
             32'h80010093, 1'b0);
        check("enc.pack_count", {16'h0, pack_count}, 32'd5);
        check("enc.err_count",  {16'h0, err_count},  32'd3);

        // Backpressure
        out_ready = 1'b0;
        set_req(2'b11, 32'h00001000, 7'h37, 3'd0, 5'd0, 5'd0, 5'd0);
        in_valid = 1'b1;
        check("bp.ready0", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        imm = 32'h00002000;
        check("bp.head_a", out_instr, 32'h00001037);
        check("bp.ready1", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        imm = 32'h00003000;
        check("bp.full", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        check("bp.held",   {31'h0, in_ready}, 32'h0);
        check("bp.head_a2", out_instr, 32'h00001037);
        check("bp.pack_held", {16'h0, pack_count}, 32'd7);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.head_b", out_instr, 32'h00002037);
        check("bp.ready_after_pop", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp.head_c", out_instr, 32'h00003037);
        check("bp.valid_c", {31'h0, out_valid}, 32'h1);
        check("bp.pack_c", {16'h0, pack_count}, 32'd8);
        @(posedge clk); #1;
        check("bp.empty", {31'h0, out_valid}, 32'h0);

        // Asynchronous reset with FIFO full and counters nonzero
        out_ready = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("ar.full", {31'h0, in_ready}, 32'h0);
        check("ar.pack_before", {16'h0, pack_count}, 32'd10);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.out_valid",  {31'h0, out_valid}, 32'h0);
        check("ar.in_ready",   {31'h0, in_ready},  32'h1);
        check("ar.pack_count", {16'h0, pack_count}, 32'h0);
        check("ar.err_count",  {16'h0, err_count},  32'h0);
        check("ar.out_instr",  out_instr, 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Saturation on the 4-bit instance: 17 accepted good requests
        set_req(2'b00, 32'h00000005, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0);
        @(posedge clk); #1;
        in_valid4 = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("sat.at15", {28'h0, pack_count4}, 32'd15);
        repeat (2) @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        check("sat.pack_count", {28'h0, pack_count4}, 32'd15);
        check("sat.err_count",  {28'h0, err_count4},  32'd0);
        check("sat.head", out_instr4, 32'h00510093);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
